// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the multi-port register bank.
// Pulled into the interface, the read-port sub-module and the regbank_mp top.
package regbank_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_PC_IDX   = 15;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rdport_state_e;

endpackage

// File: rtl/regbank_if.sv
// Bus bundle for regbank_mp: read ports, writeback, lock, PC, CPSR and scoreboard.
// The master modport is the pipeline side; the slave modport is the register bank.
interface regbank_if
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
);

  logic [NUM_RD-1:0]             rd_req;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]             rd_ack;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              lock_req;
  logic [ADDR_W-1:0] lock_addr;

  logic              pc_we;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] pc_out;

  logic              cpsr_we;
  logic [DATA_W-1:0] cpsr_in;
  logic [DATA_W-1:0] cpsr_out;

  logic [NUM_REGS-1:0] busy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, lock_req, lock_addr,
           pc_we, pc_in, cpsr_we, cpsr_in,
    input  rd_ack, rd_data, pc_out, cpsr_out, busy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, lock_req, lock_addr,
           pc_we, pc_in, cpsr_we, cpsr_in,
    output rd_ack, rd_data, pc_out, cpsr_out, busy
  );

endinterface

// File: rtl/regbank_rdport.sv
// One read port: request/ack FSM that stalls on a busy register, plus its data register.
// With REGBANK_BYPASS_EN defined, a stalled read is granted from the committing write bus.
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_req,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wr_req,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             rd_ack,
  output logic [DATA_W-1:0]                rd_data
);

  rdport_state_e     state_q, state_d;
  logic              sel_hit;
  logic              sel_busy;
  logic [DATA_W-1:0] sel_data;
  logic              grant;
  logic              load;
  logic [DATA_W-1:0] rd_val;

  // Indices past NUM_REGS match nothing: never busy, read as zero.
  always_comb begin
    sel_hit  = 1'b0;
    sel_busy = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        sel_hit  = 1'b1;
        sel_busy = busy[i];
        sel_data = mem[i];
      end
    end
  end

`ifdef REGBANK_BYPASS_EN
  logic fwd;
  assign fwd    = sel_hit && wr_req && (wr_addr == rd_addr);
  assign grant  = !sel_busy || fwd;
  assign rd_val = fwd ? wr_data : sel_data;
`else
  logic unused_wr_bus;
  assign unused_wr_bus = ^{sel_hit, wr_req, wr_addr, wr_data};
  assign grant  = !sel_busy;
  assign rd_val = sel_data;
`endif

  // NOTE: defaults are assigned before the case so every path drives
  // state_d and load; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (grant) begin
            state_d = ACK;
            load    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!rd_req) begin
          state_d = IDLE;
        end else if (grant) begin
          state_d = ACK;
          load    = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and data use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (load) rd_data <= rd_val;
    end
  end

  assign rd_ack = (state_q == ACK);

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register file with scoreboard locking, PC mirror and CPSR.
// Optional feature: define REGBANK_BYPASS_EN to forward the writeback bus to stalled reads.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int PC_IDX   = DEF_PC_IDX
) (
  input logic     clk,
  input logic     rst_n,
  regbank_if.slave bus
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic [NUM_REGS-1:0]             busy_q;
  logic [DATA_W-1:0]               cpsr_q;
  logic [DATA_W-1:0]               pc_out_q;
  logic [DATA_W-1:0]               pc_nxt;
  logic                            wr_hits_pc;

  logic [NUM_RD-1:0]             rd_ack_w;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_w;

  // Writeback outranks fetch when both target the PC in one cycle.
  assign wr_hits_pc = bus.wr_req && (bus.wr_addr == ADDR_W'(PC_IDX));

  always_comb begin
    pc_nxt = mem_q[PC_IDX];
    if (wr_hits_pc)     pc_nxt = bus.wr_data;
    else if (bus.pc_we) pc_nxt = bus.pc_in;
  end

  // NOTE: the whole register file is reset because software may read a
  // register before writing it and must see zero; that makes it flops, not RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      busy_q   <= '0;
      cpsr_q   <= '0;
      pc_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == PC_IDX) begin
          mem_q[i] <= pc_nxt;
        end else if (bus.wr_req && bus.wr_addr == ADDR_W'(i)) begin
          mem_q[i] <= bus.wr_data;
        end
        // A lock in the same cycle as the commit marks a new producer, so it wins.
        if (i != PC_IDX && bus.lock_req && bus.lock_addr == ADDR_W'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (bus.wr_req && bus.wr_addr == ADDR_W'(i)) begin
          busy_q[i] <= 1'b0;
        end
      end
      if (bus.cpsr_we) cpsr_q <= bus.cpsr_in;
      pc_out_q <= pc_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regbank_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_rdport (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_req  (bus.rd_req[p]),
      .rd_addr (bus.rd_addr[p]),
      .mem     (mem_q),
      .busy    (busy_q),
      .wr_req  (bus.wr_req),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_ack  (rd_ack_w[p]),
      .rd_data (rd_data_w[p])
    );
  end

  assign bus.rd_ack   = rd_ack_w;
  assign bus.rd_data  = rd_data_w;
  assign bus.busy     = busy_q;
  assign bus.pc_out   = pc_out_q;
  assign bus.cpsr_out = cpsr_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Self-checking bench for regbank_mp: directed scenarios, then randomized traffic
// compared against an array-based model of the register file and scoreboard.
module tb_regbank_mp;

  localparam int DW  = 32;
  localparam int NR  = 24;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int PC  = 15;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD)) bus ();

  regbank_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .PC_IDX(PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model: register array, scoreboard bits, CPSR and PC mirror.
  logic [31:0]   m_mem [NR];
  logic [NR-1:0] m_busy;
  logic [31:0]   m_cpsr;
  logic [31:0]   m_pc_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies the register-bank rules for one clock edge using the inputs now driven.
  task automatic model_edge();
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_busy   = '0;
      m_cpsr   = '0;
      m_pc_out = '0;
    end else begin
      if (bus.pc_we) m_mem[PC] = bus.pc_in;
      if (bus.wr_req && bus.wr_addr < NR) begin
        m_mem[bus.wr_addr]  = bus.wr_data;
        m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.lock_req && bus.lock_addr < NR && bus.lock_addr != PC)
        m_busy[bus.lock_addr] = 1'b1;
      if (bus.cpsr_we) m_cpsr = bus.cpsr_in;
      m_pc_out = m_mem[PC];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("pc_out", bus.pc_out, m_pc_out);
    check("cpsr_out", bus.cpsr_out, m_cpsr);
    bus.wr_req   = 1'b0;
    bus.lock_req = 1'b0;
    bus.pc_we    = 1'b0;
    bus.cpsr_we  = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic lock(input int a);
    bus.lock_req  = 1'b1;
    bus.lock_addr = AW'(a);
  endtask

  // Read of a register that is free at request time: ack and data one cycle later.
  task automatic read1(input int p, input int addr, input string tag);
    logic [31:0] exp;
    exp = (addr < NR) ? m_mem[addr] : 32'h0;
    if (BYPASS && addr < NR && bus.wr_req && bus.wr_addr == AW'(addr)) exp = bus.wr_data;
    bus.rd_req[p]  = 1'b1;
    bus.rd_addr[p] = AW'(addr);
    tick();
    check({tag, "_ack"}, 32'(bus.rd_ack[p]), 32'd1);
    check({tag, "_data"}, bus.rd_data[p], exp);
    bus.rd_req[p] = 1'b0;
    tick();
    check({tag, "_ack_drop"}, 32'(bus.rd_ack[p]), 32'd0);
  endtask

  initial begin
    int lat;
    bus.rd_req    = '0;
    bus.rd_addr   = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.lock_req  = 1'b0;
    bus.lock_addr = '0;
    bus.pc_we     = 1'b0;
    bus.pc_in     = '0;
    bus.cpsr_we   = 1'b0;
    bus.cpsr_in   = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Load state, then reset with a read in flight.
    wr(3, 32'h55); tick();
    read1(0, 3, "r3_pre_rst");
    lock(7);
    bus.cpsr_we = 1'b1; bus.cpsr_in = 32'h1;
    bus.pc_we = 1'b1;   bus.pc_in = 32'h44;
    tick();
    bus.rd_req[0] = 1'b1; bus.rd_addr[0] = AW'(3);
    rst_n = 1'b0;
    tick();
    check("rst_ack0", 32'(bus.rd_ack[0]), 32'd0);
    check("rst_rd_data0", bus.rd_data[0], 32'h0);
    check("rst_rd_data1", bus.rd_data[1], 32'h0);
    bus.rd_req[0] = 1'b0;
    rst_n = 1'b1;
    read1(1, 3, "r3_post_rst");

    // Plain write then read.
    wr(1, 32'h1234); tick();
    read1(0, 1, "r1");

    // Locked register stalls the read until writeback commits it.
    lock(2); tick();
    bus.rd_req[1] = 1'b1; bus.rd_addr[1] = AW'(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r2_stall_ack", 32'(bus.rd_ack[1]), 32'd0);
    end
    wr(2, 32'hBEEF); tick();
    lat = 0;
    while (!bus.rd_ack[1] && lat < 4) begin
      tick();
      lat++;
    end
    check("r2_lat_after_commit", 32'(lat), BYPASS ? 32'd0 : 32'd1);
    check("r2_data", bus.rd_data[1], 32'hBEEF);
    bus.rd_req[1] = 1'b0;
    tick();
    check("r2_ack_drop", 32'(bus.rd_ack[1]), 32'd0);

    // Both ports on one register in the same cycle.
    wr(5, 32'd7); tick();
    bus.rd_req = '1; bus.rd_addr[0] = AW'(5); bus.rd_addr[1] = AW'(5);
    tick();
    check("dual_ack0", 32'(bus.rd_ack[0]), 32'd1);
    check("dual_ack1", 32'(bus.rd_ack[1]), 32'd1);
    check("dual_data0", bus.rd_data[0], 32'd7);
    check("dual_data1", bus.rd_data[1], 32'd7);
    bus.rd_req = '0;
    tick();

    // Lock and write together: busy stays set; a waiting read that gives up gets no ack.
    lock(4); wr(4, 32'hA5A5); tick();
    check("r4_busy", 32'(bus.busy[4]), 32'd1);
    bus.rd_req[0] = 1'b1; bus.rd_addr[0] = AW'(4);
    tick(); check("r4_wait_ack_a", 32'(bus.rd_ack[0]), 32'd0);
    tick(); check("r4_wait_ack_b", 32'(bus.rd_ack[0]), 32'd0);
    bus.rd_req[0] = 1'b0;
    tick(); check("r4_abandon_ack", 32'(bus.rd_ack[0]), 32'd0);
    wr(4, 32'h4444); tick();
    read1(0, 4, "r4_released");

    // PC: writeback beats fetch, PC cannot be locked.
    bus.pc_we = 1'b1; bus.pc_in = 32'h100; wr(15, 32'h200); tick();
    check("pc_wr_wins", bus.pc_out, 32'h200);
    bus.pc_we = 1'b1; bus.pc_in = 32'h300; tick();
    check("pc_fetch", bus.pc_out, 32'h300);
    lock(15); tick();
    check("pc_unlockable", 32'(bus.busy[15]), 32'd0);
    read1(1, 15, "r15");

    // CPSR.
    bus.cpsr_we = 1'b1; bus.cpsr_in = 32'hF000_0000; tick();
    check("cpsr_out", bus.cpsr_out, 32'hF000_0000);

    // Upper registers and out-of-range indices.
    wr(16, 32'hCAFE_F00D); tick();
    read1(0, 16, "r16");
    wr(NR - 1, 32'h0BAD_CAFE); tick();
    read1(1, NR - 1, "r_last");
    wr(30, 32'hDEAD); lock(30); tick();
    check("oor_busy", 32'(bus.busy), 32'(m_busy));
    read1(1, 30, "r30_oor");

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      int a;
      int p;
      bus.wr_req    = ($urandom_range(0, 1) == 1);
      bus.wr_addr   = AW'($urandom_range(0, 31));
      bus.wr_data   = $urandom();
      bus.lock_req  = ($urandom_range(0, 3) == 0);
      bus.lock_addr = AW'($urandom_range(0, 31));
      bus.pc_we     = ($urandom_range(0, 3) == 0);
      bus.pc_in     = $urandom();
      bus.cpsr_we   = ($urandom_range(0, 3) == 0);
      bus.cpsr_in   = $urandom();
      a = int'($urandom_range(0, 31));
      p = int'($urandom_range(0, 1));
      if (a < NR && m_busy[a]) tick();
      else read1(p, a, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
